// File: rtl/cobra_run_monitor.sv
// cobra_run_monitor: watches a core run until halt or timeout, then checks settled
// outputs against expected values latched at start and reports a verdict.
module cobra_run_monitor #(
  parameter int PC_W       = 8,
  parameter int DATA_W     = 32,
  parameter int N_CH       = 1,
  parameter int TIMEOUT    = 1024,
  parameter int SETTLE_CYC = 1,
  parameter int HALT_MODE  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [PC_W-1:0]        end_pc_i,
  input  logic [N_CH*DATA_W-1:0] expected_i,
  input  logic [N_CH-1:0]        mask_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic [N_CH*DATA_W-1:0] out_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic                   timeout_o,
  output logic [N_CH-1:0]        mismatch_o,
  output logic [31:0]            cycle_cnt_o
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;
  state_t                 state_q, state_d;
  logic [PC_W-1:0]        end_pc_q, end_pc_d, prev_pc_q, prev_pc_d;
  logic [N_CH*DATA_W-1:0] exp_q, exp_d;
  logic [N_CH-1:0]        mask_q, mask_d, mm_q, mm_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   first_q, first_d, done_q, done_d;
  logic                   pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic [N_CH-1:0]        diff, mm_now;
  logic                   halt, expired, pass_now;
  always_comb begin
    diff = '0;
    for (int k = 0; k < N_CH; k++)
      diff[k] = out_i[k*DATA_W +: DATA_W] != exp_q[k*DATA_W +: DATA_W];
  end
  assign mm_now   = mask_q & diff;
  assign pass_now = (|mask_q) & ~(|mm_now);
  // Self-loop mode needs one RUN cycle of history before a repeat PC can count as halt.
  assign halt     = (HALT_MODE == 0) ? (pc_i == end_pc_q) : (!first_q && pc_i == prev_pc_q);
  assign expired  = cnt_q >= TO_LAST;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      end_pc_q  <= '0;
      prev_pc_q <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      mm_q      <= '0;
      settle_q  <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      end_pc_q  <= end_pc_d;
      prev_pc_q <= prev_pc_d;
      exp_q     <= exp_d;
      mask_q    <= mask_d;
      mm_q      <= mm_d;
      settle_q  <= settle_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    end_pc_d  = end_pc_q;
    prev_pc_d = prev_pc_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    mm_d      = mm_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d  = RUN;
        end_pc_d = end_pc_i;
        exp_d    = expected_i;
        mask_d   = mask_i;
        first_d  = 1'b1;
        cnt_d    = '0;
        mm_d     = '0;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        to_d     = 1'b0;
      end
      RUN: begin
        cnt_d     = &cnt_q ? cnt_q : cnt_q + 32'd1;
        first_d   = 1'b0;
        prev_pc_d = pc_i;
        if (halt) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LD;
        end else if (expired) begin
          state_d = DONE;
          done_d  = 1'b1;
          to_d    = 1'b1;
          fail_d  = 1'b1;
        end
      end
      SETTLE: begin
        settle_d = settle_q - SW'(1);
        if (settle_q == SW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          mm_d    = mm_now;
          pass_d  = pass_now;
          fail_d  = !pass_now;
        end
      end
    endcase
  end
  always_comb begin
    busy_o      = state_q == RUN || state_q == SETTLE;
    done_o      = done_q;
    pass_o      = pass_q;
    fail_o      = fail_q;
    timeout_o   = to_q;
    mismatch_o  = mm_q;
    cycle_cnt_o = cnt_q;
  end
endmodule

// File: tb/tb_cobra_run_monitor.sv
// tb_cobra_run_monitor: directed runs on three monitor configurations; verdicts
// are queued at start and checked when done_o fires.
module tb_cobra_run_monitor;
  typedef struct packed {
    logic        p;
    logic        f;
    logic        t;
    logic [1:0]  mm;
    logic [31:0] cnt;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [7:0]  end_pc, pc;
  logic [63:0] exp_w, out_w;
  logic [1:0]  mask_w;
  logic [2:0]  busy_v, done_v, pass_v, fail_v, to_v;
  logic [0:0]  mm_a, mm_c;
  logic [1:0]  mm_b;
  logic [31:0] cnt_a, cnt_b, cnt_c;
  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          w;
  always #5 clk = ~clk;
  cobra_run_monitor #(.PC_W(8), .DATA_W(32), .N_CH(1), .TIMEOUT(16), .SETTLE_CYC(1), .HALT_MODE(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_v[0]), .end_pc_i(end_pc), .expected_i(exp_w[31:0]),
    .mask_i(mask_w[0:0]), .pc_i(pc), .out_i(out_w[31:0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .pass_o(pass_v[0]), .fail_o(fail_v[0]), .timeout_o(to_v[0]), .mismatch_o(mm_a), .cycle_cnt_o(cnt_a));
  cobra_run_monitor #(.PC_W(8), .DATA_W(32), .N_CH(2), .TIMEOUT(16), .SETTLE_CYC(1), .HALT_MODE(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_v[1]), .end_pc_i(end_pc), .expected_i(exp_w),
    .mask_i(mask_w), .pc_i(pc), .out_i(out_w), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .pass_o(pass_v[1]), .fail_o(fail_v[1]), .timeout_o(to_v[1]), .mismatch_o(mm_b), .cycle_cnt_o(cnt_b));
  cobra_run_monitor #(.PC_W(8), .DATA_W(32), .N_CH(1), .TIMEOUT(64), .SETTLE_CYC(3), .HALT_MODE(0)) u_c (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_v[2]), .end_pc_i(end_pc), .expected_i(exp_w[31:0]),
    .mask_i(mask_w[0:0]), .pc_i(pc), .out_i(out_w[31:0]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .pass_o(pass_v[2]), .fail_o(fail_v[2]), .timeout_o(to_v[2]), .mismatch_o(mm_c), .cycle_cnt_o(cnt_c));
  function automatic exp_t mk(input logic p, input logic f, input logic t, input logic [1:0] mm, input logic [31:0] c);
    mk = {p, f, t, mm, c};
  endfunction
  function automatic logic [1:0] mm_of(input int d);
    mm_of = d == 0 ? {1'b0, mm_a} : d == 1 ? mm_b : {1'b0, mm_c};
  endfunction
  function automatic logic [31:0] cnt_of(input int d);
    cnt_of = d == 0 ? cnt_a : d == 1 ? cnt_b : cnt_c;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic step_pc(input logic [7:0] v);
    pc = v;
    @(negedge clk);
  endtask
  task automatic start_run(input int d, input logic [7:0] epc, input logic [63:0] e, input logic [1:0] m,
                           input bit push, input exp_t x);
    end_pc = epc;
    exp_w = e;
    mask_w = m;
    start_v[d] = 1'b1;
    if (push) sb.push_back(x);
    @(negedge clk);
    start_v = '0;
    chk("start_busy", busy_v[d], 1);
    chk("start_clear", {pass_v[d], fail_v[d], to_v[d], mm_of(d), cnt_of(d)}, 0);
  endtask
  task automatic wait_done(input int d, input string tag, output int waited);
    exp_t x;
    waited = 0;
    while (!done_v[d] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_seen"}, done_v[d], 1);
    x = sb.size() > 0 ? sb.pop_front() : '1;
    chk({tag, "_verdict"}, {pass_v[d], fail_v[d], to_v[d]}, {x.p, x.f, x.t});
    chk({tag, "_mismatch"}, mm_of(d), x.mm);
    chk({tag, "_cnt"}, cnt_of(d), x.cnt);
    chk({tag, "_busy"}, busy_v[d], 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done_v[d], 0);
    chk({tag, "_hold"}, {pass_v[d], fail_v[d], to_v[d], mm_of(d)}, {x.p, x.f, x.t, x.mm});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    start_v = '0;
    pc = '0;
    end_pc = '0;
    exp_w = '0;
    out_w = '0;
    mask_w = '0;
    #12;
    chk("rst_flags", {busy_v, done_v, pass_v, fail_v, to_v}, 0);
    chk("rst_cnt", {cnt_a, cnt_b}, 0);
    chk("rst_cnt_mm", {cnt_c, mm_a, mm_b, mm_c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // end PC and expected change after start: the latched copies must be used
    out_w = 64'hF8;
    start_run(0, 8'd5, 64'hF8, 2'b01, 1, mk(1, 0, 0, 2'b00, 32'd6));
    end_pc = 8'd9;
    exp_w = 64'h0;
    for (int i = 0; i < 6; i++) step_pc(8'(i));
    wait_done(0, "m0_pass", w);
    out_w = 64'hF0;
    start_run(0, 8'd5, 64'hF8, 2'b01, 1, mk(0, 1, 0, 2'b01, 32'd6));
    for (int i = 0; i < 6; i++) step_pc(8'(i));
    wait_done(0, "m0_fail", w);
    start_run(0, 8'd200, 64'hF8, 2'b01, 1, mk(0, 1, 1, 2'b00, 32'd16));
    pc = 8'd0;
    wait_done(0, "timeout", w);
    chk("timeout_latency", w, 16);
    out_w = 64'hF8;
    start_run(0, 8'd15, 64'hF8, 2'b01, 1, mk(1, 0, 0, 2'b00, 32'd16));
    for (int i = 0; i < 16; i++) step_pc(8'(i));
    wait_done(0, "halt_wins", w);
    start_run(0, 8'h10, 64'hF8, 2'b01, 1, mk(1, 0, 0, 2'b00, 32'd1));
    step_pc(8'h10);
    wait_done(0, "first_cyc_halt", w);
    // zero mask fails; a start pulse mid-run must not restart the count
    out_w = 64'h0;
    start_run(0, 8'd5, 64'hF8, 2'b00, 1, mk(0, 1, 0, 2'b00, 32'd6));
    for (int i = 0; i < 6; i++) begin
      start_v[0] = i == 2;
      step_pc(8'(i));
    end
    start_v = '0;
    wait_done(0, "mask0_restart", w);
    out_w = {32'h22, 32'h99};
    start_run(1, 8'd0, {32'h22, 32'h11}, 2'b10, 1, mk(1, 0, 0, 2'b00, 32'd4));
    step_pc(8'd0);
    step_pc(8'd1);
    step_pc(8'd2);
    step_pc(8'd2);
    wait_done(1, "m1_masked", w);
    start_run(1, 8'd0, {32'h22, 32'h11}, 2'b11, 1, mk(0, 1, 0, 2'b01, 32'd3));
    step_pc(8'd2);
    step_pc(8'd3);
    step_pc(8'd3);
    wait_done(1, "m1_first_cyc", w);
    start_run(1, 8'd0, {32'h22, 32'h11}, 2'b00, 1, mk(0, 1, 0, 2'b00, 32'd2));
    step_pc(8'd4);
    step_pc(8'd4);
    wait_done(1, "m1_mask0", w);
    // asynchronous abort mid-run, then a start right at reset release
    out_w = 64'hF8;
    start_run(0, 8'd5, 64'hF8, 2'b01, 0, mk(0, 0, 0, 2'b00, 32'd0));
    step_pc(8'd0);
    step_pc(8'd1);
    step_pc(8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {busy_v[0], done_v[0], pass_v[0], fail_v[0], to_v[0], mm_a, cnt_a}, 0);
    for (int i = 0; i < 3; i++) begin
      step_pc(8'(3 + i));
      chk("abort_no_done", done_v, 0);
    end
    rst_n = 1'b1;
    start_run(0, 8'd5, 64'hF8, 2'b01, 1, mk(1, 0, 0, 2'b00, 32'd6));
    for (int i = 0; i < 6; i++) step_pc(8'(i));
    wait_done(0, "after_reset", w);
    out_w = 64'h0;
    start_run(2, 8'd3, 64'hF8, 2'b01, 1, mk(1, 0, 0, 2'b00, 32'd4));
    for (int i = 0; i < 4; i++) step_pc(8'(i));
    step_pc(8'd3);
    step_pc(8'd7);
    chk("settle_busy", {busy_v[2], done_v[2]}, 2'b10);
    out_w = 64'hF8;
    wait_done(2, "settle_late_ok", w);
    out_w = 64'h0;
    start_run(2, 8'd3, 64'hF8, 2'b01, 1, mk(0, 1, 0, 2'b01, 32'd4));
    for (int i = 0; i < 4; i++) step_pc(8'(i));
    step_pc(8'd3);
    step_pc(8'd3);
    step_pc(8'd3);
    out_w = 64'hF8;
    wait_done(2, "settle_too_late", w);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cobra_run_monitor.md
COBRA_RUN_MONITOR -- requirements
Module: cobra_run_monitor

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have parameter DATA_W, default 32, width of one checked output channel.
REQ-003 SHALL have parameter N_CH, default 1, number of checked output channels (1..8).
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum RUN cycles before abort (>=2).
REQ-005 SHALL have parameter SETTLE_CYC, default 1, cycles between halt detection and result sampling (>=1).
REQ-006 SHALL have parameter HALT_MODE, default 0: 0 = halt on end-PC match, 1 = halt on PC self-loop.
REQ-007 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port start_i  in  1  begin a checked run.
REQ-010 SHALL have port end_pc_i  in  PC_W  halt PC (HALT_MODE 0), latched at start.
REQ-011 SHALL have port expected_i  in  N_CH*DATA_W  expected values, channel k at bits [k*DATA_W +: DATA_W], latched at start.
REQ-012 SHALL have port mask_i  in  N_CH  per-channel check enable, latched at start.
REQ-013 SHALL have port pc_i  in  PC_W  PC of the core under observation.
REQ-014 SHALL have port out_i  in  N_CH*DATA_W  live core outputs.
REQ-015 SHALL have port busy_o  out  1  high in RUN or SETTLE.
REQ-016 SHALL have port done_o  out  1  one-cycle pulse on entry to DONE.
REQ-017 SHALL have ports pass_o, fail_o, timeout_o  out  1 each  run verdict.
REQ-018 SHALL have port mismatch_o  out  N_CH  per-channel mismatch flags.
REQ-019 SHALL have port cycle_cnt_o  out  32  RUN cycles elapsed in current/last run.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, SETTLE, DONE.
REQ-021 start_i high in IDLE or DONE SHALL, next edge: enter RUN, latch end_pc_i/expected_i/mask_i, clear cycle_cnt_o, pass_o, fail_o, timeout_o, mismatch_o.
REQ-022 start_i in RUN or SETTLE SHALL be ignored.
REQ-023 In RUN, cycle_cnt_o SHALL increment by 1 every cycle, saturating at 2^32-1.
REQ-024 HALT_MODE 0: halt SHALL be detected in any RUN cycle where pc_i equals latched end PC, including the first RUN cycle.
REQ-025 HALT_MODE 1: halt SHALL be detected when pc_i equals pc_i of the previous RUN cycle; the first RUN cycle never detects halt.
REQ-026 On halt, SHALL enter SETTLE and load a down-counter with SETTLE_CYC.
REQ-027 In SETTLE, counter SHALL decrement each cycle; on the cycle it is 1, out_i SHALL be sampled and compared, and the FSM SHALL enter DONE next edge.
REQ-028 mismatch_o[k] SHALL equal mask[k] AND (out_i channel k != expected channel k) at the sample cycle.
REQ-029 pass_o SHALL be 1 iff mismatch_o is all-zero and latched mask is non-zero; fail_o SHALL be its complement in DONE.
REQ-030 Latched mask all-zero SHALL give fail_o=1, mismatch_o=0.
REQ-031 If cycle_cnt_o reaches TIMEOUT in RUN without halt, SHALL enter DONE with timeout_o=1, fail_o=1, pass_o=0, mismatch_o=0.
REQ-032 Halt and timeout in the same cycle: halt SHALL win.
REQ-033 done_o SHALL be high exactly one cycle, the first DONE cycle; verdict outputs SHALL hold until next start or reset.
REQ-034 pc_i changes during SETTLE SHALL be ignored.

Reset
REQ-035 rst_i low SHALL immediately force IDLE and all outputs and latched registers to 0, independent of clk_i.
REQ-036 Reset during RUN or SETTLE SHALL abort the run with no done_o pulse.
REQ-037 After rst_i rises, the first start_i SHALL be honoured on the next rising edge.

Verification
REQ-038 Mode 0, end_pc=5, pc_i 0..5 one per cycle, out_i=0xF8, expected=0xF8, mask=1 -> done_o one pulse, pass_o=1, cycle_cnt_o=6.
REQ-039 Same, out_i=0xF0 at sample -> fail_o=1, mismatch_o=1, pass_o=0.
REQ-040 TIMEOUT=16, pc_i never reaches end_pc -> done_o after 16 RUN cycles, timeout_o=1, fail_o=1.
REQ-041 Mode 1, N_CH=2, pc_i 0,1,2,2; mask=2'b10, ch0 wrong, ch1 correct -> pass_o=1, mismatch_o=2'b00.
REQ-042 rst_i low mid-RUN then start_i -> no done_o during abort; outputs 0; new run completes normally.
REQ-043 SETTLE_CYC=3, out_i becomes correct 2 cycles after halt -> pass_o=1; with out_i correct only after 4 cycles -> fail_o=1.
